// File: rtl/mem_writeback.sv
// mem_writeback: data-memory access and register writeback; MSPU_MISALIGN_TRAP_EN faults misaligned half/word.
// Latency: ALU op writes back 1 cycle after accept, memory op >= 2 cycles (req, ack, writeback).
// Backpressure: ready_out only in IDLE; a stalled dmem_ack holds the stage until ack or ACK_TIMEOUT.
module mem_writeback #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic        mem_to_reg,
    input  logic        reg_we_in,
    input  logic        mem_unsigned,
    input  logic [1:0]  alu_bytes,
    input  logic [4:0]  rd_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_dout,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        reg_we_out,
    output logic [4:0]  rd_out,
    output logic [31:0] reg_wdata,
    output logic        fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    lat_bytes;
    logic [1:0]    lat_lsb;
    logic          lat_unsigned;
    logic [4:0]    lat_rd;
    logic          lat_wb;

    logic          accept;
    logic [3:0]    be_next;
    logic [31:0]   st_data;
    logic [31:0]   shifted;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;

    assign ready_out = (state == IDLE);
    assign accept    = valid_in & ready_out & run;

`ifdef MSPU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((alu_bytes == 2'b01) && alu_result[0]) ||
                        (alu_bytes[1] && (alu_result[1:0] != 2'b00));
`endif

    // Misaligned low bits simply fall out of the lane decode here.
    always_comb begin
        be_next = 4'b1111;
        st_data = mem_dout;
        case (alu_bytes)
            2'b00: begin
                be_next = 4'b0001 << alu_result[1:0];
                st_data = {4{mem_dout[7:0]}};
            end
            2'b01: begin
                be_next = alu_result[1] ? 4'b1100 : 4'b0011;
                st_data = {2{mem_dout[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted  = dmem_rdata >> {lat_lsb, 3'b000};
        half_sel = lat_lsb[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_val = dmem_rdata;
        case (lat_bytes)
            2'b00:   load_val = {{24{~lat_unsigned & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~lat_unsigned & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            lat_bytes    <= 2'b00;
            lat_lsb      <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_rd       <= 5'd0;
            lat_wb       <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_be      <= 4'd0;
            dmem_wdata   <= 32'd0;
            reg_we_out   <= 1'b0;
            rd_out       <= 5'd0;
            reg_wdata    <= 32'd0;
            fault        <= 1'b0;
        end else begin
            reg_we_out <= 1'b0;
            fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!(mem_re | mem_we)) begin
                            reg_we_out <= reg_we_in && (rd_in != 5'd0);
                            if (reg_we_in && (rd_in != 5'd0)) begin
                                rd_out    <= rd_in;
                                reg_wdata <= alu_result;
                            end
                            state <= WB;
                        end
`ifdef MSPU_MISALIGN_TRAP_EN
                        else if (misaligned) begin
                            fault <= 1'b1;
                        end
`endif
                        else begin
                            dmem_req     <= 1'b1;
                            dmem_we      <= mem_we;
                            dmem_addr    <= {alu_result[31:2], 2'b00};
                            dmem_be      <= be_next;
                            dmem_wdata   <= st_data;
                            lat_bytes    <= alu_bytes;
                            lat_lsb      <= alu_result[1:0];
                            lat_unsigned <= mem_unsigned;
                            lat_rd       <= rd_in;
                            // A store wins over a simultaneous load and never writes back.
                            lat_wb       <= mem_re & ~mem_we & mem_to_reg & reg_we_in & (rd_in != 5'd0);
                            state        <= REQ;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (dmem_ack) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        reg_we_out <= lat_wb;
                        if (lat_wb) begin
                            rd_out    <= lat_rd;
                            reg_wdata <= load_val;
                        end
                        wait_cnt <= '0;
                        state    <= WB;
                    end else if (state == REQ) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else if ((ACK_TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        fault    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: directed vector table, hand sequences for timeout/reset/run, random ops vs. reference model.
module tb_mem_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        valid_in;
    logic        ready_out;
    logic        mem_re, mem_we, mem_to_reg, reg_we_in, mem_unsigned;
    logic [1:0]  alu_bytes;
    logic [4:0]  rd_in;
    logic [31:0] alu_result, mem_dout;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        reg_we_out;
    logic [4:0]  rd_out;
    logic [31:0] reg_wdata;
    logic        fault;

    int errors = 0;
    int checks = 0;

    mem_writeback #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .run(run), .valid_in(valid_in), .ready_out(ready_out),
        .mem_re(mem_re), .mem_we(mem_we), .mem_to_reg(mem_to_reg), .reg_we_in(reg_we_in),
        .mem_unsigned(mem_unsigned), .alu_bytes(alu_bytes), .rd_in(rd_in),
        .alu_result(alu_result), .mem_dout(mem_dout),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .reg_we_out(reg_we_out), .rd_out(rd_out), .reg_wdata(reg_wdata), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        re, we, m2r, rwe, uns;
        logic [1:0]  sz;
        logic [4:0]  rd;
        logic [31:0] res, dout, rdata;
        int          ack_wait;
    } op_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdat;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdat;
        logic        stable;
        int          req_cnt;
        int          wb_cnt;
        int          wb_cyc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fault;
        int          fault_cyc;
        logic        ready_at_fault;
        logic        ready_end;
    } obs_t;

    typedef struct {
        op_t  op;
        exp_t e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    function automatic op_t mkop(input logic re, we, m2r, rwe, uns, input logic [1:0] sz,
                                 input logic [4:0] rd, input logic [31:0] res, dout, rdata,
                                 input int ack_wait);
        op_t o;
        o.re = re; o.we = we; o.m2r = m2r; o.rwe = rwe; o.uns = uns; o.sz = sz; o.rd = rd;
        o.res = res; o.dout = dout; o.rdata = rdata; o.ack_wait = ack_wait;
        return o;
    endfunction

    function automatic exp_t mkexp(input logic req, input logic [31:0] addr, input logic [3:0] be,
                                   input logic we, input logic [31:0] wdat, input logic wb,
                                   input logic [4:0] rd, input logic [31:0] data, input logic flt);
        exp_t e;
        e.req = req; e.addr = addr; e.be = be; e.we = we; e.wdat = wdat;
        e.wb = wb; e.rd = rd; e.data = data; e.fault = flt;
        return e;
    endfunction

    // Reference model: expected bus/writeback behaviour computed arithmetically from the op.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        int          lsb;
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        e = mkexp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lsb = int'(op.res % 4);
        if (!(op.re || op.we)) begin
            e.wb = op.rwe && (op.rd != 0);
            e.rd = op.rd;
            e.data = op.res;
            return e;
        end
`ifdef MSPU_MISALIGN_TRAP_EN
        if ((op.sz == 2'd1 && (lsb % 2) == 1) || (op.sz >= 2'd2 && lsb != 0)) begin
            e.fault = 1'b1;
            return e;
        end
`endif
        e.req = 1'b1;
        e.we = op.we;
        e.addr = op.res - 32'(lsb);
        if (op.sz == 2'd0) begin
            e.be = 4'(1 << lsb);
            e.wdat = op.dout[7:0] * 32'h0101_0101;
            sh = lsb * 8;
            mask = 32'h0000_00FF;
        end else if (op.sz == 2'd1) begin
            e.be = (lsb >= 2) ? 4'b1100 : 4'b0011;
            e.wdat = op.dout[15:0] * 32'h0001_0001;
            sh = (lsb >= 2) ? 16 : 0;
            mask = 32'h0000_FFFF;
        end else begin
            e.be = 4'b1111;
            e.wdat = op.dout;
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        v = (op.rdata >> sh) & mask;
        if (!op.uns && mask != 32'hFFFF_FFFF && (v & ((mask >> 1) + 1)) != 0)
            v = v | ~mask;
        e.wb = op.re && !op.we && op.m2r && op.rwe && (op.rd != 0);
        e.rd = op.rd;
        e.data = v;
        return e;
    endfunction

    // Present one op, answer the memory port after ack_wait extra cycles, observe a fixed window.
    task automatic run_op(input string tag, input op_t op, input bit drop_run, output obs_t o);
        int req_seen;
        o = '{default: 0};
        o.stable = 1'b1;
        o.wb_cyc = -1;
        o.fault_cyc = -1;
        req_seen = 0;
        @(posedge clk); #1;
        chk({tag, ".ready"}, {31'd0, ready_out}, 32'd1);
        valid_in = 1'b1; mem_re = op.re; mem_we = op.we; mem_to_reg = op.m2r;
        reg_we_in = op.rwe; mem_unsigned = op.uns; alu_bytes = op.sz; rd_in = op.rd;
        alu_result = op.res; mem_dout = op.dout; dmem_ack = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        run = !drop_run;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dmem_req) begin
                if (req_seen == 0) begin
                    o.req = 1'b1; o.addr = dmem_addr; o.be = dmem_be; o.we = dmem_we; o.wdat = dmem_wdata;
                end else if (dmem_addr !== o.addr || dmem_be !== o.be || dmem_we !== o.we || dmem_wdata !== o.wdat) begin
                    o.stable = 1'b0;
                end
                dmem_ack = (req_seen == op.ack_wait);
                dmem_rdata = op.rdata;
                req_seen++;
            end else begin
                dmem_ack = 1'b0;
            end
            if (reg_we_out) begin
                if (o.wb_cnt == 0) o.wb_cyc = c;
                o.wb_cnt++; o.rd = rd_out; o.data = reg_wdata;
            end
            if (fault) begin
                o.fault = 1'b1; o.fault_cyc = c; o.ready_at_fault = ready_out;
            end
        end
        dmem_ack = 1'b0;
        run = 1'b1;
        o.req_cnt = req_seen;
        o.ready_end = ready_out;
    endtask

    task automatic compare(input string tag, input op_t op, input exp_t e, input obs_t o);
        chk({tag, ".req"}, {31'd0, o.req}, {31'd0, e.req});
        if (e.req) begin
            chk({tag, ".addr"}, o.addr, e.addr);
            chk({tag, ".be"}, {28'd0, o.be}, {28'd0, e.be});
            chk({tag, ".we"}, {31'd0, o.we}, {31'd0, e.we});
            chk({tag, ".stable"}, {31'd0, o.stable}, 32'd1);
            if (e.we) chk({tag, ".wdata"}, o.wdat, e.wdat);
        end
        chk({tag, ".wb_cnt"}, 32'(o.wb_cnt), {31'd0, e.wb});
        if (e.wb) begin
            chk({tag, ".rd"}, {27'd0, o.rd}, {27'd0, e.rd});
            chk({tag, ".wdat_reg"}, o.data, e.data);
            chk({tag, ".lat"}, 32'(o.wb_cyc), e.req ? 32'(op.ack_wait + 1) : 32'd0);
        end
        chk({tag, ".fault"}, {31'd0, o.fault}, {31'd0, e.fault});
        chk({tag, ".ready_end"}, {31'd0, o.ready_end}, 32'd1);
    endtask

    vec_t vecs[12];

    initial begin
        obs_t o;
        op_t  op;
        int   seen;
        int   kind;

        reset = 1'b0; run = 1'b1; valid_in = 1'b0; mem_re = 0; mem_we = 0; mem_to_reg = 0;
        reg_we_in = 0; mem_unsigned = 0; alu_bytes = 0; rd_in = 0; alu_result = 0; mem_dout = 0;
        dmem_ack = 0; dmem_rdata = 0;

        //              re we m2r rwe uns sz     rd     res           dout          rdata       ack
        vecs[0]  = '{mkop(0, 0, 0, 1, 0, 2'd2, 5'd5,  32'h1234_5678, 32'h0,         32'h0,         0),
                     mkexp(0, 0, 0, 0, 0, 1, 5'd5, 32'h1234_5678, 0)};
        vecs[1]  = '{mkop(0, 0, 0, 1, 0, 2'd2, 5'd0,  32'h1234_5678, 32'h0,         32'h0,         0),
                     mkexp(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{mkop(1, 0, 1, 1, 0, 2'd0, 5'd7,  32'h0000_0103, 32'h0,         32'h80AA_BBCC, 3),
                     mkexp(1, 32'h100, 4'b1000, 0, 0, 1, 5'd7, 32'hFFFF_FF80, 0)};
        vecs[3]  = '{mkop(1, 0, 1, 1, 1, 2'd0, 5'd8,  32'h0000_0103, 32'h0,         32'h80AA_BBCC, 3),
                     mkexp(1, 32'h100, 4'b1000, 0, 0, 1, 5'd8, 32'h0000_0080, 0)};
        vecs[4]  = '{mkop(0, 1, 0, 1, 0, 2'd1, 5'd6,  32'h0000_0202, 32'hDEAD_BEEF, 32'h0,         1),
                     mkexp(1, 32'h200, 4'b1100, 1, 32'hBEEF_BEEF, 0, 0, 0, 0)};
`ifdef MSPU_MISALIGN_TRAP_EN
        vecs[5]  = '{mkop(1, 0, 1, 1, 0, 2'd2, 5'd9,  32'h0000_0302, 32'h0,         32'hCAFE_F00D, 0),
                     mkexp(0, 0, 0, 0, 0, 0, 0, 0, 1)};
`else
        vecs[5]  = '{mkop(1, 0, 1, 1, 0, 2'd2, 5'd9,  32'h0000_0302, 32'h0,         32'hCAFE_F00D, 0),
                     mkexp(1, 32'h300, 4'b1111, 0, 0, 1, 5'd9, 32'hCAFE_F00D, 0)};
`endif
        vecs[6]  = '{mkop(1, 0, 1, 1, 0, 2'd1, 5'd10, 32'h0000_0102, 32'h0,         32'h80AA_BBCC, 2),
                     mkexp(1, 32'h100, 4'b1100, 0, 0, 1, 5'd10, 32'hFFFF_80AA, 0)};
        vecs[7]  = '{mkop(1, 0, 1, 1, 1, 2'd1, 5'd11, 32'h0000_0100, 32'h0,         32'h80AA_BBCC, 0),
                     mkexp(1, 32'h100, 4'b0011, 0, 0, 1, 5'd11, 32'h0000_BBCC, 0)};
        vecs[8]  = '{mkop(0, 1, 0, 0, 0, 2'd0, 5'd0,  32'h0000_0001, 32'h1234_565A, 32'h0,         0),
                     mkexp(1, 32'h0, 4'b0010, 1, 32'h5A5A_5A5A, 0, 0, 0, 0)};
        vecs[9]  = '{mkop(0, 1, 0, 0, 0, 2'd3, 5'd0,  32'h0000_0400, 32'h1122_3344, 32'h0,         2),
                     mkexp(1, 32'h400, 4'b1111, 1, 32'h1122_3344, 0, 0, 0, 0)};
        vecs[10] = '{mkop(1, 1, 1, 1, 0, 2'd2, 5'd4,  32'h0000_0700, 32'hAABB_CCDD, 32'h5555_5555, 0),
                     mkexp(1, 32'h700, 4'b1111, 1, 32'hAABB_CCDD, 0, 0, 0, 0)};
        vecs[11] = '{mkop(1, 0, 1, 1, 0, 2'd0, 5'd31, 32'h0000_0101, 32'h0,         32'h0000_7F00, 0),
                     mkexp(1, 32'h100, 4'b0010, 0, 0, 1, 5'd31, 32'h0000_007F, 0)};

        #3;
        chk("rst.dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst.reg_we_out", {31'd0, reg_we_out}, 32'd0);
        chk("rst.fault", {31'd0, fault}, 32'd0);
        chk("rst.addr_be", {dmem_addr[27:0], dmem_be}, 32'd0);
        chk("rst.wdata", dmem_wdata, 32'd0);
        chk("rst.regs", reg_wdata ^ {27'd0, rd_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst.ready", {31'd0, ready_out}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, 1'b0, o);
            compare($sformatf("vec%0d", i), vecs[i].op, vecs[i].e, o);
        end

        // Ack never arrives: four WAIT cycles after the REQ cycle, then fault and back to IDLE.
        op = mkop(1, 0, 1, 1, 0, 2'd2, 5'd12, 32'h0000_0600, 32'h0, 32'h0, 1000);
        run_op("timeout", op, 1'b0, o);
        chk("timeout.req_cnt", 32'(o.req_cnt), 32'd5);
        chk("timeout.fault", {31'd0, o.fault}, 32'd1);
        chk("timeout.fault_cyc", 32'(o.fault_cyc), 32'd5);
        chk("timeout.ready", {31'd0, o.ready_at_fault}, 32'd1);
        chk("timeout.no_wb", 32'(o.wb_cnt), 32'd0);

        // Reset asserted while waiting for ack.
        @(posedge clk); #1;
        valid_in = 1; mem_re = 1; mem_we = 0; mem_to_reg = 1; reg_we_in = 1; alu_bytes = 2'd2;
        rd_in = 5'd3; alu_result = 32'h500;
        @(posedge clk); #1;
        valid_in = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("rstwait.req_before", {31'd0, dmem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rstwait.req_async", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (reg_we_out || dmem_req || fault) seen++;
        end
        dmem_ack = 1'b0;
        chk("rstwait.quiet", 32'(seen), 32'd0);

        // run=0 blocks acceptance; raising run lets the held op through.
        @(posedge clk); #1;
        run = 0; valid_in = 1; mem_re = 0; mem_we = 0; reg_we_in = 1; rd_in = 5'd9; alu_result = 32'hA5A5_0009;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (reg_we_out || dmem_req || !ready_out) seen++;
        end
        chk("run0.blocked", 32'(seen), 32'd0);
        @(posedge clk); #1 run = 1;
        @(posedge clk); #1 valid_in = 0;
        @(negedge clk);
        chk("run1.we", {31'd0, reg_we_out}, 32'd1);
        chk("run1.rd", {27'd0, rd_out}, 32'd9);
        chk("run1.data", reg_wdata, 32'hA5A5_0009);

        for (int i = 0; i < 120; i++) begin
            kind = int'($urandom_range(0, 2));
            op.re = (kind == 1);
            op.we = (kind == 2);
            if (kind == 2 && ($urandom % 4) == 0) op.re = 1'b1;
            op.sz = 2'($urandom);
            op.res = $urandom;
            op.dout = $urandom;
            op.rdata = $urandom;
            op.rd = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom);
            op.rwe = (($urandom % 4) != 0);
            op.m2r = op.re && (($urandom % 4) != 0);
            op.uns = 1'($urandom);
            op.ack_wait = int'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d", i), op, 1'($urandom), o);
            compare($sformatf("rnd%0d", i), op, model(op), o);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
